pipelined_ripple_adder: RTL and testbench

PIPELINED_RIPPLE_ADDER -- requirements
Module: pipelined_ripple_adder

---
 rtl/pipelined_ripple_adder.sv | 168 ++++++++++++++++
 tb/tb_pipelined_ripple_adder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_ripple_adder.sv
// Pipelined ripple-carry adder with a valid/ready handshake on both sides.
// Each stage adds one SEG_W-bit slice of the operands plus the carry from
// the stage before it. Skew registers carry the not-yet-added upper operand
// slices and the finished lower sum slices, so every result leaves aligned.
// Optional feature macro: PIPELINED_RIPPLE_ADDER_OVF_EN adds the signed
// overflow output 'ovf'.
module pipelined_ripple_adder #(
    parameter int WIDTH = 16,
    parameter int SEG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    // SEG_SAFE keeps the derived sizes legal long enough for the
    // configuration check below to report a bad SEG_W.
    localparam int SEG_SAFE = (SEG_W < 1) ? 1 : SEG_W;
    localparam int STAGES   = (WIDTH / SEG_SAFE < 1) ? 1 : (WIDTH / SEG_SAFE);
    localparam int LAST     = STAGES - 1;

    generate
        if ((SEG_W < 1) || ((WIDTH % SEG_SAFE) != 0)) begin : g_bad_cfg
            $error("pipelined_ripple_adder: WIDTH must be a positive multiple of SEG_W");
        end
    endgenerate

    // Per-stage state: valid bit, operand copies, partial sum, slice carry.
    logic [STAGES-1:0]                 valid_q, valid_d;
    logic [STAGES-1:0][WIDTH-1:0]      a_q, a_d;
    logic [STAGES-1:0][WIDTH-1:0]      b_q, b_d;
    logic [STAGES-1:0][WIDTH-1:0]      sum_q, sum_d;
    logic [STAGES-1:0]                 carry_q, carry_d;

    // What each stage would capture: the input port for stage 0, the
    // previous stage's registers for everything after it.
    logic [STAGES-1:0]                 src_valid;
    logic [STAGES-1:0]                 src_carry;
    logic [STAGES-1:0][WIDTH-1:0]      src_a;
    logic [STAGES-1:0][WIDTH-1:0]      src_b;
    logic [STAGES-1:0][WIDTH-1:0]      src_sum;

    // Slice result per stage, carry-out in the top bit.
    logic [STAGES-1:0][SEG_SAFE:0]     seg_res;

    // ld[k]: stage k captures new contents this cycle (empty or draining).
    logic [STAGES-1:0]                 ld;
    logic                              down_rdy;

    // Stall chain: a stage may load when it is empty or the stage ahead of
    // it can take its contents; the last stage drains on out_ready.
    always_comb begin
        down_rdy = out_ready;
        ld       = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            ld[k]    = !valid_q[k] || down_rdy;
            down_rdy = ld[k];
        end
    end

    // Route the input port into stage 0 and each stage into the next.
    always_comb begin
        src_valid    = '0;
        src_carry    = '0;
        src_a        = '0;
        src_b        = '0;
        src_sum      = '0;
        src_valid[0] = in_valid;
        src_carry[0] = cin;
        src_a[0]     = a;
        src_b[0]     = b;
        src_sum[0]   = '0;
        for (int k = 1; k < STAGES; k++) begin
            src_valid[k] = valid_q[k-1];
            src_carry[k] = carry_q[k-1];
            src_a[k]     = a_q[k-1];
            src_b[k]     = b_q[k-1];
            src_sum[k]   = sum_q[k-1];
        end
    end

    // Slice adders and next-state: load a freshly added slice, else hold.
    always_comb begin
        seg_res = '0;
        valid_d = valid_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        for (int k = 0; k < STAGES; k++) begin
            seg_res[k] = {1'b0, src_a[k][k*SEG_SAFE +: SEG_SAFE]}
                       + {1'b0, src_b[k][k*SEG_SAFE +: SEG_SAFE]}
                       + {{SEG_SAFE{1'b0}}, src_carry[k]};
            if (ld[k]) begin
                valid_d[k]                         = src_valid[k];
                a_d[k]                             = src_a[k];
                b_d[k]                             = src_b[k];
                sum_d[k]                           = src_sum[k];
                sum_d[k][k*SEG_SAFE +: SEG_SAFE]   = seg_res[k][SEG_SAFE-1:0];
                carry_d[k]                         = seg_res[k][SEG_SAFE];
            end
        end
    end

    // Pipeline registers; reset empties every stage and zeroes the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= '0;
        end else begin
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    // The last stage's operand copies have no consumer downstream.
    logic unused_last_ops;
    assign unused_last_ops = ^{a_q[LAST], b_q[LAST]};

`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
    logic ovf_q, ovf_d;

    // Signed overflow: carry into the MSB (recovered from the MSB sum bit)
    // XOR carry out of the MSB, captured alongside the last slice.
    always_comb begin
        ovf_d = ovf_q;
        if (ld[LAST]) begin
            ovf_d = src_a[LAST][WIDTH-1] ^ src_b[LAST][WIDTH-1]
                  ^ seg_res[LAST][SEG_SAFE-1] ^ seg_res[LAST][SEG_SAFE];
        end
    end

    // Overflow flag register, aligned with the last stage's sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign in_ready  = ld[0];
    assign out_valid = valid_q[LAST];
    assign sum       = sum_q[LAST];
    assign cout      = carry_q[LAST];

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Directed self-checking bench for pipelined_ripple_adder.
// Main instance: WIDTH=16, SEG_W=4 (four stages). A second instance with
// SEG_W=16 covers the single-stage build.
module tb_pipelined_ripple_adder;

   localparam int W   = 16;
   localparam int STG = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid, in_ready, out_valid, out_ready, cin, cout;
   logic [W-1:0]  a, b, sum;
   logic          s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_cin, s_cout;
   logic [W-1:0]  s_a, s_b, s_sum;
`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
   logic          ovf, s_ovf;
`endif

   int            checks   = 0;
   int            failures = 0;
   logic [W:0]    exp_q[$];
   int            pushed    = 0;
   int            popped    = 0;
   int            cycle     = 0;
   int            fire_cnt  = 0;
   int            first_fire = -1;
   int            last_fire  = -1;
   logic          prev_stall = 1'b0;
   logic [W:0]    prev_out   = '0;
   logic          saw_in_ready_low = 1'b0;

   pipelined_ripple_adder #(.WIDTH(W), .SEG_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout)
`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   pipelined_ripple_adder #(.WIDTH(W), .SEG_W(16)) dut_single (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (s_in_valid),
      .in_ready  (s_in_ready),
      .a         (s_a),
      .b         (s_b),
      .cin       (s_cin),
      .out_valid (s_out_valid),
      .out_ready (s_out_ready),
      .sum       (s_sum),
      .cout      (s_cout)
`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
      ,
      .ovf       (s_ovf)
`endif
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // One comparison: count it, and count and report it if it disagrees.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // One handshake cycle against the scoreboard: drive, let it settle,
   // check outputs and in_ready, record transfers, then clock.
   task automatic applyStimulus(input logic v, input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                                input logic op_c, input logic rdy);
      logic [W:0] expv;
      in_valid  = v;
      a         = op_a;
      b         = op_b;
      cin       = op_c;
      out_ready = rdy;
      #1;
      checkOutput("in_ready", {31'b0, in_ready}, {31'b0, (rdy || ((pushed - popped) < STG))});
      if (!in_ready) saw_in_ready_low = 1'b1;
      if (pushed == popped) checkOutput("idle_valid", {31'b0, out_valid}, 32'd0);
      if (prev_stall) begin
         checkOutput("hold_valid", {31'b0, out_valid}, 32'd1);
         checkOutput("hold_data", {15'b0, cout, sum}, {15'b0, prev_out});
      end
      if (out_valid && rdy && (exp_q.size() > 0)) begin
         expv = exp_q.pop_front();
         checkOutput("result", {15'b0, cout, sum}, {15'b0, expv});
         popped++;
         fire_cnt++;
         if (first_fire < 0) first_fire = cycle;
         last_fire = cycle;
      end
      prev_stall = out_valid && !rdy;
      prev_out   = {cout, sum};
      if (v && in_ready) begin
         exp_q.push_back({1'b0, op_a} + {1'b0, op_b} + {{W{1'b0}}, op_c});
         pushed++;
      end
      @(posedge clk);
      #1;
      cycle++;
   endtask

   // Single operation into an empty pipe, checking latency and the result.
   task automatic runSingle(input string tag, input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                            input logic op_c, input logic [W-1:0] exp_sum, input logic exp_cout,
                            input logic exp_ovf);
      a         = op_a;
      b         = op_b;
      cin       = op_c;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      checkOutput({tag, ".in_ready"}, {31'b0, in_ready}, 32'd1);
      for (int n = 1; n <= STG + 1; n++) begin
         @(posedge clk);
         #1;
         if (n == 1) in_valid = 1'b0;
         checkOutput($sformatf("%s.valid@%0d", tag, n), {31'b0, out_valid}, {31'b0, (n == STG)});
         if (n == STG) begin
            checkOutput({tag, ".sum"}, {16'b0, sum}, {16'b0, exp_sum});
            checkOutput({tag, ".cout"}, {31'b0, cout}, {31'b0, exp_cout});
`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
            checkOutput({tag, ".ovf"}, {31'b0, ovf}, {31'b0, exp_ovf});
`else
            if (exp_ovf === 1'bx) $display("[TB] %s: unexpected X in overflow expectation", tag);
`endif
         end
      end
   endtask

   initial begin
      int base_pop;
      int base_push;
      int idx;
      logic rdy;

      rst_n       = 1'b0;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      a           = '0;
      b           = '0;
      cin         = 1'b0;
      s_in_valid  = 1'b0;
      s_out_ready = 1'b1;
      s_a         = '0;
      s_b         = '0;
      s_cin       = 1'b0;

      // Reset state.
      #8;
      checkOutput("rst.out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("rst.sum", {16'b0, sum}, 32'd0);
      checkOutput("rst.cout", {31'b0, cout}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      checkOutput("rel.in_ready", {31'b0, in_ready}, 32'd1);

      // Directed single operations; the first accept is on the first edge after release.
      $display("[TB] single-operation vectors");
      runSingle("ffff+1",    16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      runSingle("ffff+ffff", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
      runSingle("7fff+1",    16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
      runSingle("8000+8000", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
      runSingle("1234+4321", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
      runSingle("0f0f+00f1", 16'h0F0F, 16'h00F1, 1'b1, 16'h1001, 1'b0, 1'b0);

      // Back-to-back stream: eight results on consecutive cycles, in order.
      $display("[TB] back-to-back stream");
      base_pop   = popped;
      fire_cnt   = 0;
      first_fire = -1;
      last_fire  = -1;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 16'(i), 16'(2 * i), 1'(i & 1), 1'b1);
      end
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
      end
      checkOutput("b2b.count", 32'(popped - base_pop), 32'd8);
      checkOutput("b2b.span", 32'(last_fire - first_fire), 32'd7);
      checkOutput("b2b.latency", 32'(first_fire - (cycle - 14)), 32'(STG));

      // Backpressure: stall the output for six cycles mid-stream, then drain.
      $display("[TB] backpressure");
      base_pop         = popped;
      base_push        = pushed;
      saw_in_ready_low = 1'b0;
      for (int c = 0; c < 40; c++) begin
         idx = pushed - base_push;
         rdy = !((c >= 2) && (c < 8));
         applyStimulus(idx < 10, 16'(idx * 32'h1111), 16'(32'hF00F ^ (idx << 4)), 1'(idx & 1), rdy);
         if ((pushed - base_push) >= 10 && pushed == popped) break;
      end
      checkOutput("bp.in_ready_fell", {31'b0, saw_in_ready_low}, 32'd1);
      checkOutput("bp.drained", 32'(popped - base_pop), 32'd10);
      checkOutput("bp.queue_empty", 32'(exp_q.size()), 32'd0);

      // Reset with operations in flight: nothing from before it may appear.
      $display("[TB] mid-flight reset");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 16'(16'h0100 + i), 16'h0001, 1'b0, 1'b0);
      end
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
      checkOutput("mid.valid_before", {31'b0, out_valid}, 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("mid.valid_during", {31'b0, out_valid}, 32'd0);
      checkOutput("mid.sum_during", {16'b0, sum}, 32'd0);
      checkOutput("mid.cout_during", {31'b0, cout}, 32'd0);
      exp_q.delete();
      pushed     = 0;
      popped     = 0;
      prev_stall = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
      end

      // Single-stage build: result one edge after acceptance.
      $display("[TB] single-stage instance");
      s_a        = 16'd3;
      s_b        = 16'd6;
      s_cin      = 1'b1;
      s_in_valid = 1'b1;
      #1;
      checkOutput("s1.in_ready", {31'b0, s_in_ready}, 32'd1);
      checkOutput("s1.valid_before", {31'b0, s_out_valid}, 32'd0);
      @(posedge clk);
      #1;
      s_a   = 16'hFFFF;
      s_b   = 16'hFFFF;
      s_cin = 1'b1;
      checkOutput("s1.valid", {31'b0, s_out_valid}, 32'd1);
      checkOutput("s1.sum", {16'b0, s_sum}, 32'd10);
      checkOutput("s1.cout", {31'b0, s_cout}, 32'd0);
      @(posedge clk);
      #1;
      s_in_valid = 1'b0;
      checkOutput("s2.valid", {31'b0, s_out_valid}, 32'd1);
      checkOutput("s2.sum", {16'b0, s_sum}, 32'h0000FFFF);
      checkOutput("s2.cout", {31'b0, s_cout}, 32'd1);
      @(posedge clk);
      #1;
      checkOutput("s3.valid", {31'b0, s_out_valid}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
